// File: rtl/cpu_seq_pkg.sv
// Shared types for the single-cycle MIPS step sequencer: the sequencer
// state encoding, the register-address width and a port-ownership helper.
package cpu_seq_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    INSPECT  = 2'd0,
    SETTLE_C = 2'd1,
    RUN      = 2'd2,
    SETTLE_I = 2'd3
  } seq_state_t;

  // The processor drives register-file port 1 in SETTLE_C and RUN.
  // The inspector drives it in the other two states.
  function automatic logic owns_cpu(seq_state_t s);
    return (s == SETTLE_C) || (s == RUN);
  endfunction

endpackage

// File: rtl/cpu_step_sequencer_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous level, followed by a
// registered rising-edge detector. The output level appears two cycles after
// the input changes. The edge pulse appears one cycle after that and is
// exactly one cycle wide.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus the one-cycle rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: owns the processor clock-enable for the single-cycle
// MIPS datapath and arbitrates register-file read port 1 between the processor
// and the switch-driven register inspector.
//
// Free-run issues one cpu_ce per tick while switchRun is high. A rising edge
// on stepBtn in INSPECT runs exactly one instruction. After every change of
// port owner, the port is held idle for SETTLE cycles.
//
// Optional feature: define CPU_SEQ_BREAKPOINT_EN to add the breakpoint inputs
// bp_valid, bp_addr and pc, and the bp_hit output.
//
// All outputs are registered. Each output is computed from the next state, so
// the output and the state change on the same edge. A cpu_ce pulse therefore
// always falls in a cycle where the state is RUN and the processor owns the
// port. The SETTLE parameter must be at least 1.
module cpu_step_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  switchRun,
  input  logic                  stepBtn,
  input  logic [REG_ADDR_W-1:0] SwitchSelector,
  input  logic [REG_ADDR_W-1:0] cpu_read_addr,
  input  logic                  cpu_RegWrite,
  output logic                  cpu_ce,
  output logic [REG_ADDR_W-1:0] rf_read_addr_1,
  output logic                  rf_RegWrite,
  output logic                  view_pc,
  output logic [CNT_W-1:0]      retired,
  output logic                  LEDIndicator
`ifdef CPU_SEQ_BREAKPOINT_EN
  ,
  input  logic                  bp_valid,
  input  logic [7:0]            bp_addr,
  input  logic [7:0]            pc,
  output logic                  bp_hit
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  // Synchronized inputs.
  logic run_level;
  logic run_rise;
  logic step_level;
  logic step_rise;

  sync_edge u_run_sync (
    .clk   (clk),
    .reset (reset),
    .din   (switchRun),
    .level (run_level),
    .rise  (run_rise)
  );

  sync_edge u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (stepBtn),
    .level (step_level),
    .rise  (step_rise)
  );

  // The FSM state and the settle counter.
  // step_mode marks a single-step excursion. That excursion issues its one
  // pulse without waiting for a tick and then always returns to INSPECT.
  seq_state_t    state;
  seq_state_t    state_next;
  logic          step_mode;
  logic          step_next;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] cnt_next;
  logic          ce_next;
  logic          bp_set;
  logic          bp_match;
  logic          bp_hold;

`ifdef CPU_SEQ_BREAKPOINT_EN
  assign bp_match = bp_valid && (pc == bp_addr);
  assign bp_hold  = bp_hit;

  // A breakpoint latches bp_hit. bp_hit clears on the next step or on a new
  // rising edge of switchRun. While bp_hit is set, a high switchRun does not
  // restart free-run.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit <= 1'b0;
    end else if (bp_set) begin
      bp_hit <= 1'b1;
    end else if (step_rise || run_rise) begin
      bp_hit <= 1'b0;
    end
  end

  logic unused_sync;
  assign unused_sync = step_level;
`else
  assign bp_match = 1'b0;
  assign bp_hold  = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{step_level, run_rise, bp_set};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INSPECT;
      step_mode  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      step_mode  <= step_next;
      settle_cnt <= cnt_next;
    end
  end

  // Next-state logic and the next value of cpu_ce.
  // The settle counter returns to zero whenever it is not counting. Each
  // settle state therefore starts counting from zero.
  always_comb begin
    state_next = state;
    step_next  = step_mode;
    cnt_next   = '0;
    ce_next    = 1'b0;
    bp_set     = 1'b0;
    case (state)
      INSPECT: begin
        if (run_level && !bp_hold) begin
          state_next = SETTLE_C;
          step_next  = 1'b0;
        end else if (step_rise) begin
          state_next = SETTLE_C;
          step_next  = 1'b1;
        end
      end
      SETTLE_C: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = RUN;
          ce_next    = step_mode ? 1'b1 : (tick & ~bp_match);
        end else begin
          cnt_next = settle_cnt + SW'(1);
        end
      end
      RUN: begin
        if (step_mode) begin
          // The step pulse is issued in this cycle. Return the port to the
          // inspector next.
          state_next = SETTLE_I;
          step_next  = 1'b0;
        end else if (!cpu_ce && bp_match) begin
          state_next = SETTLE_I;
          bp_set     = 1'b1;
        end else if (tick && !cpu_ce) begin
          // Stay in RUN for the pulse cycle, even if switchRun has fallen.
          ce_next = 1'b1;
        end else if (!run_level) begin
          state_next = SETTLE_I;
        end
      end
      SETTLE_I: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = INSPECT;
        end else begin
          cnt_next = settle_cnt + SW'(1);
        end
      end
      default: state_next = INSPECT;
    endcase
  end

  // Registered outputs. Each one is computed from the next state, so it
  // changes in the same cycle the new state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ce         <= 1'b0;
      rf_RegWrite    <= 1'b0;
      rf_read_addr_1 <= SwitchSelector;
      view_pc        <= 1'b0;
      retired        <= '0;
      LEDIndicator   <= 1'b0;
    end else begin
      cpu_ce         <= ce_next;
      rf_RegWrite    <= ce_next & cpu_RegWrite;
      rf_read_addr_1 <= owns_cpu(state_next) ? cpu_read_addr : SwitchSelector;
      view_pc        <= (state_next == RUN);
      if (ce_next) begin
        retired      <= retired + CNT_W'(1);
        LEDIndicator <= ~LEDIndicator;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer. The run uses a narrow retired counter so
// that the counter wraps within a short test.
//
// Expected values come from a behavioural model. Each tick in RUN produces
// one pulse in the next cycle. That pulse carries the write-enable and
// read address presented with the tick. A step produces one pulse six cycles
// after the button edge. retired and LEDIndicator follow the running count of
// expected pulses.
module tb_cpu_step_sequencer;
  import cpu_seq_pkg::*;

  localparam int CNT_W  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             switchRun;
  logic             stepBtn;
  logic [4:0]       SwitchSelector;
  logic [4:0]       cpu_read_addr;
  logic             cpu_RegWrite;
  logic             cpu_ce;
  logic [4:0]       rf_read_addr_1;
  logic             rf_RegWrite;
  logic             view_pc;
  logic [CNT_W-1:0] retired;
  logic             LEDIndicator;
`ifdef CPU_SEQ_BREAKPOINT_EN
  logic             bp_valid;
  logic [7:0]       bp_addr;
  logic [7:0]       pc;
  logic             bp_hit;
`endif

  int tests = 0;
  int fails = 0;
  int exp_pulses = 0;

  // Monitor counters: pulses seen, writes outside a pulse, back-to-back pulses.
  int   pulse_cnt = 0;
  int   we_bad = 0;
  int   adj_bad = 0;
  logic prev_ce = 1'b0;

  cpu_step_sequencer #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .switchRun      (switchRun),
    .stepBtn        (stepBtn),
    .SwitchSelector (SwitchSelector),
    .cpu_read_addr  (cpu_read_addr),
    .cpu_RegWrite   (cpu_RegWrite),
    .cpu_ce         (cpu_ce),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_RegWrite    (rf_RegWrite),
    .view_pc        (view_pc),
    .retired        (retired),
    .LEDIndicator   (LEDIndicator)
`ifdef CPU_SEQ_BREAKPOINT_EN
    ,
    .bp_valid       (bp_valid),
    .bp_addr        (bp_addr),
    .pc             (pc),
    .bp_hit         (bp_hit)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

`ifdef CPU_SEQ_BREAKPOINT_EN
  // PC model: the PC advances by 4 on each pulse.
  always @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (cpu_ce) pc <= pc + 8'd4;
  end
`endif

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_ce) pulse_cnt++;
      if (rf_RegWrite && !cpu_ce) we_bad++;
      if (cpu_ce && prev_ce) adj_bad++;
      prev_ce = cpu_ce;
    end else begin
      prev_ce = 1'b0;
    end
  end

  // Advance n clocks and return 1 time unit after the last rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0;
    stepBtn = 1'b0;
    cycles(3);
    reset = 1'b0;
    exp_pulses = 0;
  endtask

  task automatic test_reset();
    int base;
    logic [4:0] sel;
    switchRun = 1'b0;
    SwitchSelector = 5'd9;
    cpu_read_addr = 5'd3;
    cpu_RegWrite = 1'b1;
    do_reset();
    tests++; if (rf_read_addr_1 !== 5'd9) begin fails++; $display("FAIL reset_addr: got %0d want 9", rf_read_addr_1); end
    tests++; if (cpu_ce !== 1'b0 || rf_RegWrite !== 1'b0) begin fails++; $display("FAIL reset_ce: got ce=%b we=%b want 0 0", cpu_ce, rf_RegWrite); end
    tests++; if (view_pc !== 1'b0 || LEDIndicator !== 1'b0) begin fails++; $display("FAIL reset_view_led: got %b %b want 0 0", view_pc, LEDIndicator); end
    tests++; if (retired !== '0) begin fails++; $display("FAIL reset_retired: got %0d want 0", retired); end
    tests++; if (dut.state !== INSPECT) begin fails++; $display("FAIL reset_state: got %0d want INSPECT", dut.state); end
    base = pulse_cnt;
    for (int i = 0; i < 1000; i++) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(2);
    end
    tests++; if (pulse_cnt - base !== 0) begin fails++; $display("FAIL inspect_no_pulse: got %0d pulses want 0", pulse_cnt - base); end
    tests++; if (retired !== '0) begin fails++; $display("FAIL inspect_retired: got %0d want 0", retired); end
    for (int i = 0; i < 6; i++) begin
      sel = 5'($urandom_range(0, 31));
      SwitchSelector = sel;
      cycles(1);
      tests++; if (rf_read_addr_1 !== sel) begin fails++; $display("FAIL inspect_addr: got %0d want %0d", rf_read_addr_1, sel); end
    end
    SwitchSelector = 5'd9;
  endtask

  task automatic test_run();
    int base;
    cpu_read_addr = 5'd3;
    cpu_RegWrite = 1'b1;
    switchRun = 1'b1;
    cycles(10);
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(3);
      exp_pulses++;
    end
    cycles(2);
    tests++; if (pulse_cnt - base !== 5) begin fails++; $display("FAIL run_pulses: got %0d want 5", pulse_cnt - base); end
    tests++; if (retired !== CNT_W'(exp_pulses % (1 << CNT_W))) begin fails++; $display("FAIL run_retired: got %0d want %0d", retired, exp_pulses % (1 << CNT_W)); end
    tests++; if (LEDIndicator !== 1'(exp_pulses % 2)) begin fails++; $display("FAIL run_led: got %b want %0d", LEDIndicator, exp_pulses % 2); end
    tests++; if (view_pc !== 1'b1) begin fails++; $display("FAIL run_view_pc: got %b want 1", view_pc); end
    tests++; if (rf_read_addr_1 !== 5'd3) begin fails++; $display("FAIL run_addr: got %0d want 3", rf_read_addr_1); end
  endtask

  task automatic test_random_run();
    int gap;
    logic [4:0] addr;
    logic we;
    for (int i = 0; i < 20; i++) begin
      gap = $urandom_range(1, 6);
      for (int g = 0; g < gap; g++) begin
        cycles(1);
        tests++; if (cpu_ce !== 1'b0 || rf_RegWrite !== 1'b0) begin fails++; $display("FAIL rand_idle: got ce=%b we=%b want 0 0", cpu_ce, rf_RegWrite); end
      end
      addr = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      cpu_read_addr = addr;
      cpu_RegWrite = we;
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      exp_pulses++;
      tests++; if (cpu_ce !== 1'b1) begin fails++; $display("FAIL rand_pulse: got %b want 1", cpu_ce); end
      tests++; if (rf_RegWrite !== we) begin fails++; $display("FAIL rand_we: got %b want %b", rf_RegWrite, we); end
      tests++; if (rf_read_addr_1 !== addr) begin fails++; $display("FAIL rand_addr: got %0d want %0d", rf_read_addr_1, addr); end
    end
    cycles(2);
    tests++; if (retired !== CNT_W'(exp_pulses % (1 << CNT_W))) begin fails++; $display("FAIL rand_retired: got %0d want %0d", retired, exp_pulses % (1 << CNT_W)); end
  endtask

  task automatic test_step();
    int base;
    logic want;
    cpu_RegWrite = 1'b1;
    switchRun = 1'b0;
    cycles(10);
    tests++; if (dut.state !== INSPECT) begin fails++; $display("FAIL step_pre_state: got %0d want INSPECT", dut.state); end
    base = pulse_cnt;
    stepBtn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cycles(1);
      want = (k == 6);
      tests++; if (cpu_ce !== want) begin fails++; $display("FAIL step_timing: cycle %0d got ce=%b want %b", k, cpu_ce, want); end
      if (k == 6) begin
        tests++; if (rf_RegWrite !== 1'b1) begin fails++; $display("FAIL step_we: got %b want 1", rf_RegWrite); end
      end
      if (k == 2) stepBtn = 1'b0;
      if (k == 4) stepBtn = 1'b1;
    end
    cycles(20);
    stepBtn = 1'b0;
    cycles(5);
    exp_pulses++;
    tests++; if (pulse_cnt - base !== 1) begin fails++; $display("FAIL step_count: got %0d want 1", pulse_cnt - base); end
    tests++; if (dut.state !== INSPECT || view_pc !== 1'b0) begin fails++; $display("FAIL step_return: got state=%0d view=%b want INSPECT 0", dut.state, view_pc); end
    tests++; if (retired !== CNT_W'(exp_pulses % (1 << CNT_W))) begin fails++; $display("FAIL step_retired: got %0d want %0d", retired, exp_pulses % (1 << CNT_W)); end
  endtask

  task automatic test_drop_with_tick();
    logic want;
    cpu_read_addr = 5'd3;
    cpu_RegWrite = 1'b1;
    SwitchSelector = 5'd20;
    switchRun = 1'b1;
    cycles(10);
    tick = 1'b1;
    switchRun = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycles(1);
      if (k == 1) tick = 1'b0;
      want = (k == 1);
      tests++; if (cpu_ce !== want || rf_RegWrite !== want) begin fails++; $display("FAIL drop_pulse: cycle %0d got ce=%b we=%b want %b", k, cpu_ce, rf_RegWrite, want); end
      if (k >= 2 + 1 + SETTLE) begin
        tests++; if (rf_read_addr_1 !== 5'd20) begin fails++; $display("FAIL drop_addr: cycle %0d got %0d want 20", k, rf_read_addr_1); end
      end
    end
    exp_pulses++;
    tests++; if (dut.state !== INSPECT) begin fails++; $display("FAIL drop_state: got %0d want INSPECT", dut.state); end
    tests++; if (retired !== CNT_W'(exp_pulses % (1 << CNT_W))) begin fails++; $display("FAIL drop_retired: got %0d want %0d", retired, exp_pulses % (1 << CNT_W)); end
  endtask

  task automatic test_wrap();
    do_reset();
    switchRun = 1'b1;
    cycles(10);
    for (int i = 0; i < 17; i++) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(2);
      exp_pulses++;
    end
    cycles(2);
    tests++; if (retired !== CNT_W'(1)) begin fails++; $display("FAIL wrap_retired: got %0d want 1", retired); end
    tests++; if (LEDIndicator !== 1'b1) begin fails++; $display("FAIL wrap_led: got %b want 1", LEDIndicator); end
  endtask

  task automatic test_reset_mid_step();
    int base;
    switchRun = 1'b0;
    SwitchSelector = 5'd17;
    cycles(10);
    base = pulse_cnt;
    stepBtn = 1'b1;
    cycles(4);
    tests++; if (dut.state !== SETTLE_C) begin fails++; $display("FAIL midstep_state: got %0d want SETTLE_C", dut.state); end
    reset = 1'b1;
    stepBtn = 1'b0;
    cycles(1);
    reset = 1'b0;
    exp_pulses = 0;
    tests++; if (cpu_ce !== 1'b0 || rf_RegWrite !== 1'b0 || view_pc !== 1'b0 || LEDIndicator !== 1'b0) begin fails++; $display("FAIL midstep_outs: got ce=%b we=%b view=%b led=%b want 0 0 0 0", cpu_ce, rf_RegWrite, view_pc, LEDIndicator); end
    tests++; if (retired !== '0 || rf_read_addr_1 !== 5'd17) begin fails++; $display("FAIL midstep_vals: got retired=%0d addr=%0d want 0 17", retired, rf_read_addr_1); end
    tests++; if (dut.state !== INSPECT) begin fails++; $display("FAIL midstep_inspect: got %0d want INSPECT", dut.state); end
    cycles(20);
    tests++; if (pulse_cnt - base !== 0) begin fails++; $display("FAIL midstep_no_pulse: got %0d want 0", pulse_cnt - base); end
  endtask

`ifdef CPU_SEQ_BREAKPOINT_EN
  task automatic test_breakpoint();
    int base;
    bp_valid = 1'b1;
    bp_addr = 8'h0C;
    do_reset();
    base = pulse_cnt;
    switchRun = 1'b1;
    cycles(10);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(3);
    end
    cycles(10);
    tests++; if (pulse_cnt - base !== 3) begin fails++; $display("FAIL bp_pulses: got %0d want 3", pulse_cnt - base); end
    tests++; if (bp_hit !== 1'b1) begin fails++; $display("FAIL bp_hit_set: got %b want 1", bp_hit); end
    tests++; if (dut.state !== INSPECT) begin fails++; $display("FAIL bp_state: got %0d want INSPECT", dut.state); end
    base = pulse_cnt;
    stepBtn = 1'b1;
    cycles(15);
    stepBtn = 1'b0;
    cycles(5);
    tests++; if (pulse_cnt - base !== 1) begin fails++; $display("FAIL bp_step: got %0d want 1", pulse_cnt - base); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL bp_hit_clear: got %b want 0", bp_hit); end
    tests++; if (pc !== 8'h10) begin fails++; $display("FAIL bp_pc: got %h want 10", pc); end
    switchRun = 1'b0;
    bp_valid = 1'b0;
    cycles(10);
  endtask
`endif

  task automatic test_invariants();
    tests++; if (we_bad !== 0) begin fails++; $display("FAIL inv_we_outside_ce: got %0d want 0", we_bad); end
    tests++; if (adj_bad !== 0) begin fails++; $display("FAIL inv_adjacent_ce: got %0d want 0", adj_bad); end
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    switchRun = 1'b0;
    stepBtn = 1'b0;
    SwitchSelector = 5'd0;
    cpu_read_addr = 5'd0;
    cpu_RegWrite = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
    bp_valid = 1'b0;
    bp_addr = 8'h00;
`endif
    test_reset();
    test_run();
    test_random_run();
    test_step();
    test_drop_with_tick();
    test_wrap();
    test_reset_mid_step();
`ifdef CPU_SEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
